// File: rtl/jam_pkg.sv
// Shared definitions for the job-assignment engine and its cost table.
//   N_JOBS   : workers = jobs = 8
//   IDX_W    : worker/job index width
//   COST_W   : width of one cost entry
//   SUM_W    : width of a sum of eight costs (max 8*127 = 1016)
//   COST_MAX : largest representable cost, also the row-minimum start value
//   jam_state_t : cost-table load/finalize/ready states
package jam_pkg;

    localparam int N_JOBS    = 8;
    localparam int IDX_W     = 3;
    localparam int COST_W    = 7;
    localparam int SUM_W     = 10;
    localparam int N_ENTRIES = N_JOBS * N_JOBS;
    localparam int K_W       = 2 * IDX_W;

    localparam logic [COST_W-1:0] COST_MAX = 7'd127;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        FINALIZE = 2'd1,
        READY    = 2'd2
    } jam_state_t;

endpackage

// File: rtl/jam_rowmin_acc.sv
// Row-minimum tracker and lower-bound accumulator for jam_cost_table.
// Only instantiated when JAM_COST_ROWMIN_EN is defined.
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   clear           : restart (reload) - row minima back to COST_MAX, sums to 0
//   store           : a table entry is being stored this cycle
//   store_row       : worker index of the stored entry
//   store_data      : value of the stored entry
//   fin_step        : one FINALIZE cycle; adds rowmin[fin_idx] into the sum
//   fin_idx         : row being accumulated
//   fin_last        : final FINALIZE cycle; result is published on LowerBound
//   LowerBound      : sum over workers of the row minimum (0 until published)
module jam_rowmin_acc
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic              store,
    input  logic [IDX_W-1:0]  store_row,
    input  logic [COST_W-1:0] store_data,
    input  logic              fin_step,
    input  logic [IDX_W-1:0]  fin_idx,
    input  logic              fin_last,
    output logic [SUM_W-1:0]  LowerBound
);

    function automatic logic [COST_W-1:0] min_cost(input logic [COST_W-1:0] a,
                                                   input logic [COST_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [COST_W-1:0] rowmin [N_JOBS];
    logic [SUM_W-1:0]  sum_p1;
    logic [SUM_W-1:0]  sum_next;

    // Sum cannot exceed 1016, so a plain SUM_W-bit add never wraps.
    assign sum_next = sum_p1 + SUM_W'(rowmin[fin_idx]);

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            for (int i = 0; i < N_JOBS; i++) begin
                rowmin[i] <= COST_MAX;
            end
            sum_p1     <= '0;
            LowerBound <= '0;
        end else begin
            if (store) begin
                rowmin[store_row] <= min_cost(rowmin[store_row], store_data);
            end
            if (fin_step) begin
                sum_p1 <= sum_next;
                // Published together with the move into READY.
                if (fin_last) begin
                    LowerBound <= sum_next;
                end
            end
        end
    end

endmodule

// File: rtl/jam_cost_table.sv
// 8x8 worker/job cost table for the job-assignment engine.
// Entries arrive row-major over a valid/ready stream; once all 64 are stored
// the table answers (W, J) lookups with a registered Cost one cycle later.
// Optional feature macro: JAM_COST_ROWMIN_EN - tracks per-worker row minima,
// adds an 8-cycle FINALIZE state and publishes their sum on LowerBound.
// Without the macro LowerBound is tied to 0 and LOAD goes straight to READY.
// Ports:
//   CLK, RST     : clock, synchronous active-high reset
//   load_valid   : load_data holds an entry this cycle
//   load_ready   : table accepts an entry this cycle (LOAD state)
//   load_data    : cost entry, worker-major / job-minor order
//   reload       : one-cycle pulse, discard the table and restart loading
//   W, J         : lookup indices
//   Cost         : registered cost[W][J] (0 unless the table is ready)
//   table_ready  : table complete, lookups valid
//   LowerBound   : sum of row minima (macro build), else 0
module jam_cost_table
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [COST_W-1:0] load_data,
    input  logic              reload,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    output logic              table_ready,
    output logic [SUM_W-1:0]  LowerBound
);

`ifdef JAM_COST_ROWMIN_EN
    localparam jam_state_t LOAD_DONE = FINALIZE;
`else
    localparam jam_state_t LOAD_DONE = READY;
`endif

    jam_state_t        state;
    logic [K_W-1:0]    k;
    logic [COST_W-1:0] cost_mem [N_ENTRIES];
    logic [COST_W-1:0] cost_p1;
    logic              accept;

    assign load_ready  = (state == LOAD);
    assign table_ready = (state == READY);

    // A same-cycle reload or reset discards the offered entry.
    assign accept = load_valid && load_ready && !reload && !RST;

`ifdef JAM_COST_ROWMIN_EN
    logic [IDX_W-1:0] fin_cnt;
    logic             fin_step;
    logic             fin_last;

    assign fin_step = (state == FINALIZE) && !reload;
    assign fin_last = fin_step && (&fin_cnt);

    always_ff @(posedge CLK) begin
        if (RST || reload || state != FINALIZE) begin
            fin_cnt <= '0;
        end else begin
            fin_cnt <= fin_cnt + IDX_W'(1);
        end
    end

    jam_rowmin_acc u_rowmin_acc (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (reload),
        .store      (accept),
        .store_row  (k[K_W-1:IDX_W]),
        .store_data (load_data),
        .fin_step   (fin_step),
        .fin_idx    (fin_cnt),
        .fin_last   (fin_last),
        .LowerBound (LowerBound)
    );
`else
    assign LowerBound = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= LOAD;
            k     <= '0;
        end else if (reload) begin
            state <= LOAD;
            k     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        k <= k + K_W'(1);
                        if (&k) begin
                            state <= LOAD_DONE;
                        end
                    end
                end
                FINALIZE: begin
`ifdef JAM_COST_ROWMIN_EN
                    if (&fin_cnt) begin
                        state <= READY;
                    end
`else
                    state <= READY;
`endif
                end
                READY:   state <= READY;
                default: state <= LOAD;
            endcase
        end
    end

    // Table storage: contents survive reload and reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            cost_mem[k] <= load_data;
        end
    end

    // Lookup stage: W/J sampled here, Cost valid for the following cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cost_p1 <= '0;
        end else if (state == READY) begin
            cost_p1 <= cost_mem[{W, J}];
        end else begin
            cost_p1 <= '0;
        end
    end

    assign Cost = cost_p1;

endmodule

// File: doc/jam_cost_table.md
# jam_cost_table

Upstream cost source for the job-assignment engine: stores the 8×8 worker/job cost matrix loaded over a valid/ready stream. It answers the engine's (W, J) lookups with a registered 7-bit Cost one cycle later. It also signals when the table is complete and, optionally, publishes a row-minimum lower bound the engine can use for pruning.

## Interface
- N_JOBS, 8, workers = jobs; fixed at 8 (3-bit indices).
- COST_W, 7, cost entry width.
- SUM_W, 10, width of summed costs (8×127 = 1016 fits).
- CLK  input  1  single clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  table accepts an entry this cycle.
- load_data  input  COST_W  cost entry, row-major: worker-major, job-minor.
- reload  input  1  one-cycle pulse; discard the table and restart loading.
- W  input  3  worker index of the lookup.
- J  input  3  job index of the lookup.
- Cost  output  COST_W  registered cost[W][J].
- table_ready  output  1  table complete; lookups valid.
- LowerBound  output  SUM_W  sum over workers of the row minimum.

## Operation
- States:
  - LOAD: after reset; load_ready=1.
  - FINALIZE: present only with the macro.
  - READY: table_ready=1, load_ready=0.
- Accept when load_valid && load_ready. 6-bit counter k stores the entry at row k[5:3], column k[2:0], then k increments.
- Accept of entry k=63:
  - without the macro → READY;
  - with the macro → FINALIZE.
- FINALIZE: 8 cycles. Cycle i adds rowmin[i] into the sum register; then → READY.
- LowerBound updates only on entry to READY. It holds 0 outside READY.
- READY, reload=1 → LOAD. k, the sum and table_ready clear; rowmin[*] set to 127. Table contents are not cleared.
- reload in LOAD or FINALIZE restarts LOAD with k=0.
- reload wins over a same-cycle load handshake: the entry is not stored and k=0.
- Cost register:
  - in READY, loads table[W][J] every cycle;
  - in any other state, loads 0.
- load_valid while load_ready=0 is ignored; no entry is dropped into the table.
- Reset values:
  - state=LOAD, k=0, Cost=0, table_ready=0, LowerBound=0, load_ready=1 (combinational from state);
  - rowmin[*]=127 (macro builds only);
  - table RAM contents undefined.
- Reset mid-load or mid-FINALIZE: everything above is restored and partial data is discarded.

## Timing
- Load throughput: 1 entry/cycle; a full table takes 64 accepting cycles, with gaps allowed.
- table_ready rises:
  - without the macro: in the cycle after the edge accepting entry 63;
  - with the macro: 8 cycles later.
- Lookup latency: W/J sampled at edge t; Cost valid after edge t, stable until edge t+1. The engine presents W/J one cycle ahead of its Cost sample.
- rowmin[w] updates on the same edge the entry is stored: rowmin[w] ← min(rowmin[w], load_data).
- Adds in FINALIZE are unsigned SUM_W-bit with no saturation needed; the maximum is 1016.

## Configuration
- JAM_COST_ROWMIN_EN defined:
  - 8 row-minimum registers;
  - FINALIZE state;
  - LowerBound driven as specified.
- Not defined:
  - no rowmin registers and no FINALIZE; LOAD → READY directly;
  - LowerBound tied to 0.
- Port list is identical in both builds.

## Structure
- Shared package jam_pkg:
  - N_JOBS, COST_W, SUM_W;
  - index width 3;
  - state enum {LOAD, FINALIZE, READY};
  - COST_MAX=127.
- The engine imports the same package for its Cost/MinCost widths.
- One sub-module, jam_rowmin_acc: rowmin registers, min-compare on accept, FINALIZE accumulator, LowerBound register. Instantiated only under JAM_COST_ROWMIN_EN.
- Table storage is a 64×7 register array in the top; no memory macro.

## Test plan
- Reset, then load 64 entries with value 8w+j, no gaps → table_ready 1 cycle after the last accept (9 with the macro). W=3, J=5 → Cost=29 next cycle; LowerBound=224 (macro build).
- Before table_ready, drive W=7, J=7 → Cost=0; load_valid toggled randomly during the load → exactly 64 entries stored, in order.
- All entries 127 → LowerBound=1016. Entry (2,4)=0 and the rest 127 → LowerBound=889.
- After READY: reload pulse plus load_valid in the same cycle → table_ready=0 next cycle, k=0, entry not stored. Reload 64 entries of value 1 → LowerBound=8, W=0, J=0 → Cost=1.
- Assert RST after 20 accepted entries → next cycle table_ready=0, load_ready=1, Cost=0. A fresh 64-entry load completes normally with no entry count carried over.
- Non-macro build: same as the first scenario → table_ready 1 cycle after the last accept, LowerBound=0 throughout.
